regfile_mp: RTL and testbench

- Parametrised successor to the single-write/dual-read RV32I register file.
- Provides NUM_RD read ports and NUM_WR write ports.
- Adds optional write-to-read bypass and a per-register busy scoreboard so a pipelined core can detect RAW hazards.
- Sits in the decode stage: read ports feed operand muxes, write ports come from writeback, the reserve port comes from issue.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_scoreboard.sv | 66 ++++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the multi-port register file.
// Parametrised instances derive their own widths from these defaults.
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);

  typedef logic [AW_DEF-1:0]   reg_addr_t;
  typedef logic [XLEN_DEF-1:0] xword_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection.
// Holds the busy vector, the reserve-over-clear priority and the busy count.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG   = NREG_DEF,
  parameter int NUM_WR = 1,
  localparam int AW    = $clog2(NREG),
  localparam int CW    = $clog2(NREG) + 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_WR-1:0]          we,
  input  logic [NUM_WR-1:0][AW-1:0]  wa,
  input  logic                       rsv_en,
  input  logic [AW-1:0]              rsv_addr,
  output logic [NREG-1:0]            busy,
  output logic [CW-1:0]              busy_cnt
);

  logic [NREG-1:0] busy_r;
  logic [NREG-1:0] busy_next_s;
  logic [CW-1:0]   cnt_r;

  function automatic logic [CW-1:0] popcount(input logic [NREG-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int k = 0; k < NREG; k++) begin
      c = c + CW'(v[k]);
    end
    return c;
  endfunction

  // Next busy vector: retiring writes clear, a new reservation overrides them.
  always_comb begin
    busy_next_s = busy_r;
    for (int i = 0; i < NUM_WR; i++) begin
      if (we[i] && (wa[i] != {AW{1'b0}})) begin
        busy_next_s[wa[i]] = 1'b0;
      end else begin
        busy_next_s = busy_next_s;
      end
    end
    if (rsv_en && (rsv_addr != {AW{1'b0}})) begin
      busy_next_s[rsv_addr] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
    busy_next_s[0] = 1'b0;
  end

  // Busy state and its registered popcount (lags the busy vector by one cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_r <= {NREG{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      busy_r <= busy_next_s;
      cnt_r  <= popcount(busy_r);
    end
  end

  assign busy     = busy_r;
  assign busy_cnt = cnt_r;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port architectural register file with optional write-to-read bypass
// and a busy scoreboard; register 0 is hardwired to zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD-1:0][AW-1:0]    ra,
  output logic [NUM_RD-1:0][XLEN-1:0]  rd,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            we,
  input  logic [NUM_WR-1:0][AW-1:0]    wa,
  input  logic [NUM_WR-1:0][XLEN-1:0]  wd,
  input  logic                         rsv_en,
  input  logic [AW-1:0]                rsv_addr,
  output logic [$clog2(NREG):0]        busy_cnt
);

  logic [XLEN-1:0]   regs_r [NREG];
  logic [NREG-1:0]   busy_s;
  logic [NUM_RD-1:0] hit_s;

  regfile_scoreboard #(
    .NREG   (NREG),
    .NUM_WR (NUM_WR)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wa       (wa),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy     (busy_s),
    .busy_cnt (busy_cnt)
  );

  // Data array; later write ports override earlier ones on an address collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_r[r] <= {XLEN{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_WR; i++) begin
        if (we[i] && (wa[i] != {AW{1'b0}})) begin
          regs_r[wa[i]] <= wd[i];
        end
      end
    end
  end

  // Read mux with bypass; outputs are forced to zero while reset is held.
  always_comb begin
    rd      = {(NUM_RD*XLEN){1'b0}};
    rd_busy = {NUM_RD{1'b0}};
    hit_s   = {NUM_RD{1'b0}};
    for (int j = 0; j < NUM_RD; j++) begin
      if (!rst || (ra[j] == {AW{1'b0}})) begin
        rd[j]      = {XLEN{1'b0}};
        rd_busy[j] = 1'b0;
      end else begin
        rd[j]      = regs_r[ra[j]];
        rd_busy[j] = busy_s[ra[j]];
        for (int i = 0; i < NUM_WR; i++) begin
          if ((BYPASS != 0) && we[i] && (wa[i] == ra[j])) begin
            rd[j]    = wd[i];
            hit_s[j] = 1'b1;
          end else begin
            hit_s[j] = hit_s[j];
          end
        end
        // A forwarded value is no longer pending unless it is being re-reserved.
        if (hit_s[j]) begin
          rd_busy[j] = rsv_en && (rsv_addr == ra[j]);
        end else begin
          rd_busy[j] = rd_busy[j];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassing single-write instance and a
// non-bypassing dual-write instance, checked against hand-computed values.
module tb_regfile_mp;

  logic clk;
  logic rst;

  logic [1:0][4:0]  ra_a;
  logic [1:0][31:0] rd_a;
  logic [1:0]       rdb_a;
  logic [0:0]       we_a;
  logic [0:0][4:0]  wa_a;
  logic [0:0][31:0] wd_a;
  logic             rsv_en_a;
  logic [4:0]       rsv_addr_a;
  logic [5:0]       cnt_a;

  logic [1:0][4:0]  ra_b;
  logic [1:0][31:0] rd_b;
  logic [1:0]       rdb_b;
  logic [1:0]       we_b;
  logic [1:0][4:0]  wa_b;
  logic [1:0][31:0] wd_b;
  logic             rsv_en_b;
  logic [4:0]       rsv_addr_b;
  logic [5:0]       cnt_b;

  int total;
  int bad;

  regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .ra(ra_a), .rd(rd_a), .rd_busy(rdb_a),
    .we(we_a), .wa(wa_a), .wd(wd_a), .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a),
    .busy_cnt(cnt_a)
  );

  regfile_mp #(.XLEN(32), .NREG(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .ra(ra_b), .rd(rd_b), .rd_busy(rdb_b),
    .we(we_b), .wa(wa_b), .wd(wd_b), .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b),
    .busy_cnt(cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    ra_a = '0; we_a = '0; wa_a = '0; wd_a = '0; rsv_en_a = 1'b0; rsv_addr_a = '0;
    ra_b = '0; we_b = '0; wa_b = '0; wd_b = '0; rsv_en_b = 1'b0; rsv_addr_b = '0;
    #2 rst = 1'b0;
    #1;
    ra_a[0] = 5'd3;
    check("reset_rd", rd_a[0], 32'd0);
    check("reset_busy", {31'd0, rdb_a[0]}, 32'd0);
    check("reset_cnt", {26'd0, cnt_a}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // 1: fill registers 1..31 with their index, read back on both ports
    for (int i = 1; i < 32; i++) begin
      we_a[0] = 1'b1; wa_a[0] = 5'(i); wd_a[0] = 32'(i);
      we_b[0] = 1'b1; wa_b[0] = 5'(i); wd_b[0] = 32'(i);
      tick();
    end
    we_a = '0; we_b = '0;
    for (int k = 0; k < 32; k++) begin
      ra_a[0] = 5'(k);
      ra_a[1] = 5'(31 - k);
      #1;
      check("fill_rd0", rd_a[0], 32'(k));
      check("fill_rd1", rd_a[1], 32'(31 - k));
      check("fill_busy", {30'd0, rdb_a}, 32'd0);
    end

    // 2: same-cycle bypass vs. stored-state read
    ra_a[0] = 5'd5; we_a[0] = 1'b1; wa_a[0] = 5'd5; wd_a[0] = 32'hDEADBEEF;
    ra_b[0] = 5'd5; we_b[0] = 1'b1; wa_b[0] = 5'd5; wd_b[0] = 32'hDEADBEEF;
    #1;
    check("byp_same", rd_a[0], 32'hDEADBEEF);
    check("byp_busy", {31'd0, rdb_a[0]}, 32'd0);
    check("nobyp_old", rd_b[0], 32'd5);
    tick();
    we_a = '0; we_b = '0;
    #1;
    check("byp_next", rd_a[0], 32'hDEADBEEF);
    check("nobyp_next", rd_b[0], 32'hDEADBEEF);

    // 3: register 0 ignores writes and reserves
    ra_a[0] = 5'd0; we_a[0] = 1'b1; wa_a[0] = 5'd0; wd_a[0] = 32'hFFFFFFFF;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd0;
    #1;
    check("r0_rd_same", rd_a[0], 32'd0);
    tick();
    we_a = '0; rsv_en_a = 1'b0;
    tick();
    check("r0_rd", rd_a[0], 32'd0);
    check("r0_busy", {31'd0, rdb_a[0]}, 32'd0);
    check("r0_cnt", {26'd0, cnt_a}, 32'd0);

    // 4: reserve 7, then retire it with a write
    ra_a[0] = 5'd7; rsv_en_a = 1'b1; rsv_addr_a = 5'd7;
    #1;
    check("rsv7_pre", {31'd0, rdb_a[0]}, 32'd0);
    tick();
    rsv_en_a = 1'b0;
    check("rsv7_busy", {31'd0, rdb_a[0]}, 32'd1);
    check("rsv7_cnt_lag", {26'd0, cnt_a}, 32'd0);
    tick();
    check("rsv7_cnt", {26'd0, cnt_a}, 32'd1);
    we_a[0] = 1'b1; wa_a[0] = 5'd7; wd_a[0] = 32'd42;
    #1;
    check("wr7_byp", rd_a[0], 32'd42);
    check("wr7_byp_busy", {31'd0, rdb_a[0]}, 32'd0);
    tick();
    we_a = '0;
    check("wr7_rd", rd_a[0], 32'd42);
    check("wr7_busy", {31'd0, rdb_a[0]}, 32'd0);
    check("wr7_cnt_lag", {26'd0, cnt_a}, 32'd1);
    tick();
    check("wr7_cnt", {26'd0, cnt_a}, 32'd0);

    // 5: reserve beats clear; dual-write collision takes the higher port
    ra_a[0] = 5'd9; rsv_en_a = 1'b1; rsv_addr_a = 5'd9;
    we_a[0] = 1'b1; wa_a[0] = 5'd9; wd_a[0] = 32'd100;
    we_b = 2'b11; wa_b[0] = 5'd3; wa_b[1] = 5'd3; wd_b[0] = 32'd11; wd_b[1] = 32'd22;
    tick();
    rsv_en_a = 1'b0; we_a = '0; we_b = '0;
    ra_b[0] = 5'd3;
    #1;
    check("rw9_rd", rd_a[0], 32'd100);
    check("rw9_busy", {31'd0, rdb_a[0]}, 32'd1);
    check("coll_rd", rd_b[0], 32'd22);
    check("coll_busy", {31'd0, rdb_b[0]}, 32'd0);
    tick();
    check("rw9_cnt", {26'd0, cnt_a}, 32'd1);

    // 6: reserve 1..4 (9 still busy), then asynchronous reset mid-cycle
    for (int r = 1; r <= 4; r++) begin
      rsv_en_a = 1'b1; rsv_addr_a = 5'(r);
      tick();
    end
    rsv_en_a = 1'b0;
    tick();
    check("rsv14_cnt", {26'd0, cnt_a}, 32'd5);
    ra_a[0] = 5'd1;
    #1;
    check("rsv1_busy", {31'd0, rdb_a[0]}, 32'd1);
    check("rsv1_rd", rd_a[0], 32'd1);
    we_a[0] = 1'b1; wa_a[0] = 5'd1; wd_a[0] = 32'd77;
    rst = 1'b0;
    #1;
    check("arst_rd", rd_a[0], 32'd0);
    check("arst_busy", {31'd0, rdb_a[0]}, 32'd0);
    check("arst_cnt", {26'd0, cnt_a}, 32'd0);
    we_a = '0;
    tick();
    rst = 1'b1;
    tick();
    check("post_rst_rd", rd_a[0], 32'd0);
    check("post_rst_cnt", {26'd0, cnt_a}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
